// File: rtl/uart_cmd_framer_if.sv
// Bundles the receiver byte stream, the command handshake, the error pulses and the echo outputs.
// The framer connects through the slave modport and its environment through the master modport.
interface uart_cmd_framer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_timeout;
    logic        err_range;
    logic        err_overrun;
    logic [15:0] echo_word;
    logic        echo_start;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_code, cmd_addr, cmd_valid,
        input  err_timeout, err_range, err_overrun,
        input  echo_word, echo_start
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_code, cmd_addr, cmd_valid,
        output err_timeout, err_range, err_overrun,
        output echo_word, echo_start
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// Groups UART bytes into {command, address} frames and offers them on a valid/ready handshake.
// Optional frame echo toward the transmitter is enabled by defining UART_CMD_ECHO_EN.
module uart_cmd_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 110000,
    parameter logic [7:0]  CMD_MAX        = 8'h07,
    parameter logic [7:0]  ADDR_MAX       = 8'h1F
) (
    input logic              clk,
    input logic              rst_n,
    uart_cmd_framer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_byte_q;
    logic [7:0]       cmd_code_q;
    logic [7:0]       cmd_addr_q;
    logic             cmd_valid_q;
    logic             err_timeout_q;
    logic             err_range_q;
    logic             err_overrun_q;
    logic             frame_ok;
    logic             frame_accept;

    // Frame is legal when the stored command is 1..CMD_MAX and the incoming address is in range.
    assign frame_ok     = (cmd_byte_q != 8'h00) && (cmd_byte_q <= CMD_MAX) &&
                          (bus.rx_data <= ADDR_MAX);
    assign frame_accept = (state_q == WAIT_ADDR) && bus.rx_valid && frame_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_byte_q    <= 8'h00;
            cmd_code_q    <= 8'h00;
            cmd_addr_q    <= 8'h00;
            cmd_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_range_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            err_timeout_q <= 1'b0;
            err_range_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_valid) begin
                        cmd_byte_q <= bus.rx_data;
                        cnt_q      <= '0;
                        state_q    <= WAIT_ADDR;
                    end
                end
                WAIT_ADDR: begin
                    // A byte on the deadline cycle wins over the timeout.
                    if (bus.rx_valid) begin
                        if (frame_ok) begin
                            cmd_code_q  <= cmd_byte_q;
                            cmd_addr_q  <= bus.rx_data;
                            cmd_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            err_range_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    // Bytes arriving while a frame is held are dropped, even on the accept cycle.
                    if (bus.rx_valid) begin
                        err_overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_code    = cmd_code_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_overrun = err_overrun_q;

`ifdef UART_CMD_ECHO_EN
    logic [15:0] echo_word_q;
    logic        echo_start_q;

    // Capture each accepted frame for the transmitter, pulsing start as cmd_valid rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_word_q  <= 16'h0000;
            echo_start_q <= 1'b0;
        end else begin
            echo_start_q <= frame_accept;
            if (frame_accept) begin
                echo_word_q <= {cmd_byte_q, bus.rx_data};
            end
        end
    end

    assign bus.echo_word  = echo_word_q;
    assign bus.echo_start = echo_start_q;
`else
    logic unused_accept;
    assign unused_accept  = frame_accept;
    assign bus.echo_word  = 16'h0000;
    assign bus.echo_start = 1'b0;
`endif

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sits directly downstream of the UART receiver. Collects received bytes into 2-byte command frames: byte 0 is the command code, byte 1 is the address.
- Validates each frame and presents it to the control logic over a valid/ready handshake.
- Drops incomplete frames after an inter-byte timeout and flags out-of-range and overrun conditions.

Parameters:
- TIMEOUT_CYCLES, 110000: max clk cycles allowed between byte 0 and byte 1 (about 2 byte times at 9600 baud / 50 MHz).
- CMD_MAX, 8'h07: highest legal command code; code 8'h00 is always illegal.
- ADDR_MAX, 8'h1F: highest legal address.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  single-cycle strobe from the receiver, synchronous to clk.
- cmd_code  out  8  command of the held frame.
- cmd_addr  out  8  address of the held frame.
- cmd_valid  out  1  frame available.
- cmd_ready  in  1  consumer accepts the frame when cmd_valid & cmd_ready.
- err_timeout  out  1  1-cycle pulse: byte 1 missed its deadline.
- err_range  out  1  1-cycle pulse: frame rejected (bad command or address).
- err_overrun  out  1  1-cycle pulse: byte dropped while a frame was held.
- echo_word  out  16  see Optional Feature.
- echo_start  out  1  see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs 0: cmd_code, cmd_addr, cmd_valid, all err_* pulses, echo_word, echo_start. Timeout counter 0. Reset mid-frame discards the partial frame silently, with no error pulse.
- States:
  - IDLE: on rx_valid, latch rx_data into the cmd register, clear the counter, go to WAIT_ADDR.
  - WAIT_ADDR: counter increments each cycle without rx_valid.
    - On rx_valid: if cmd in 1..CMD_MAX and rx_data <= ADDR_MAX, latch the address, set cmd_valid=1 next cycle, go to HOLD. Otherwise pulse err_range and go to IDLE.
    - If the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: pulse err_timeout, go to IDLE. The timeout has priority only when no rx_valid occurs in that same cycle; a byte arriving on the deadline cycle is accepted.
  - HOLD: cmd_valid=1; cmd_code and cmd_addr are stable.
    - On cmd_valid & cmd_ready: cmd_valid=0 next cycle, go to IDLE.
    - Any rx_valid while in HOLD pulses err_overrun, and the byte is discarded. This includes the cycle the handshake completes: acceptance is processed and the byte is still dropped.
- Latency: the last byte strobe at cycle N gives cmd_valid=1 at cycle N+1.
- cmd_valid never drops without a handshake, except on reset.
- cmd_code and cmd_addr hold their last values after acceptance.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- Error pulses are exactly 1 cycle wide. At most one err_* output is asserted per cycle.
- Back-to-back rx_valid on consecutive cycles is legal and must be handled. Example: byte 0 at cycle N, byte 1 at cycle N+1.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- Defined: on every accepted frame (the cycle cmd_valid rises), echo_word={cmd_code,cmd_addr} is registered and echo_start pulses high for 1 cycle. This drives the transmitter to echo the frame back to the host. echo_word holds its value until the next accepted frame.
- Undefined: echo_word and echo_start are tied to 0, and no echo logic is synthesized.

Test Plan:
- Normal frame: rx 8'h03, then 8'h01 after 1000 cycles. Expect cmd_valid=1 one cycle after the second strobe, with cmd_code=8'h03 and cmd_addr=8'h01. Assert cmd_ready for 1 cycle: cmd_valid=0 next cycle and state returns to IDLE.
- Timeout: rx 8'h02 then nothing. Expect err_timeout to pulse once at cycle TIMEOUT_CYCLES after the strobe and no cmd_valid. Next, rx 8'h04, 8'h05: frame {04,05} accepted.
- Range errors:
  - rx 8'h00, 8'h01: err_range pulse.
  - rx 8'h08, 8'h01: err_range pulse.
  - rx 8'h01, 8'h20: err_range pulse.
  - None of these may assert cmd_valid.
- Overrun: frame {01,02} held with cmd_ready=0, then rx 8'hAA. Expect err_overrun pulse, and cmd_code/cmd_addr stay 01/02. Raise cmd_ready in the same cycle as another rx_valid: frame accepted and err_overrun still pulses.
- Reset mid-frame: rx 8'h03, then rst_n=0 for 1 cycle, then rx 8'h01. Expect no error pulse and no cmd_valid; the state is WAIT_ADDR with cmd=8'h01.
- With UART_CMD_ECHO_EN defined: frame {06,1F}. Expect echo_start pulse in the same cycle cmd_valid rises, with echo_word=16'h061F. Without the macro, both stay 0.
